// File: rtl/operand_loader.sv
// Operand entry stage ahead of the adder: captures A then B from the switches.
// Optional button debounce filter is enabled by defining OPERAND_DEBOUNCE_EN.
module operand_loader #(
    parameter int WIDTH           = 6,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw,
    input  logic             load_btn,
    input  logic             clear_btn,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             valid,
    output logic             wait_A_LED,
    output logic             wait_B_LED,
    output logic [3:0]       pair_cnt
);

    typedef enum logic [1:0] {
        WAIT_A = 2'd0,
        WAIT_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_prev;
    logic [1:0] w_level;
    logic [1:0] w_evt;
    logic       w_load_evt;
    logic       w_clear_evt;

    // Bit 0 carries the load button, bit 1 the clear button.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= {clear_btn, load_btn};
            r_sync2 <= r_sync1;
        end
    end

`ifdef OPERAND_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] r_cnt [2];
    logic [1:0]    r_filt;

    // Level flips on the Nth consecutive cycle of disagreement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_filt <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_filt[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= 2'b00;
        end else begin
            r_prev <= w_level;
        end
    end

    assign w_evt       = w_level & ~r_prev;
    assign w_load_evt  = w_evt[0];
    assign w_clear_evt = w_evt[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= WAIT_A;
            A        <= '0;
            B        <= '0;
            valid    <= 1'b0;
            pair_cnt <= 4'd0;
        end else if (w_clear_evt) begin
            r_state <= WAIT_A;
            A       <= '0;
            B       <= '0;
            valid   <= 1'b0;
        end else if (w_load_evt) begin
            case (r_state)
                WAIT_A: begin
                    A       <= sw;
                    r_state <= WAIT_B;
                end
                WAIT_B: begin
                    B        <= sw;
                    valid    <= 1'b1;
                    pair_cnt <= pair_cnt + 4'd1;
                    r_state  <= HOLD;
                end
                HOLD: begin
                    A       <= sw;
                    valid   <= 1'b0;
                    r_state <= WAIT_B;
                end
                default: begin
                    r_state <= WAIT_A;
                end
            endcase
        end
    end

    assign wait_A_LED = (r_state == WAIT_A);
    assign wait_B_LED = (r_state == WAIT_B);

endmodule

// File: tb/tb_operand_loader.sv
// Scoreboard bench for operand_loader: expected outputs are queued per press
// and compared exactly at the capture edge, one edge earlier, and after release.
module tb_operand_loader;

    typedef struct packed {
        logic [5:0] a;
        logic [5:0] b;
        logic       v;
        logic [3:0] c;
        logic       la;
        logic       lb;
    } exp_t;

`ifdef OPERAND_DEBOUNCE_EN
    localparam int LAT = 16;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       reset_n;
    logic [5:0] sw;
    logic       load_btn;
    logic       clear_btn;
    logic [5:0] A;
    logic [5:0] B;
    logic       valid;
    logic       wait_A_LED;
    logic       wait_B_LED;
    logic [3:0] pair_cnt;

    int n_err = 0;
    int n_chk = 0;

    logic [5:0] m_a;
    logic [5:0] m_b;
    logic       m_v;
    logic [3:0] m_c;
    int         m_st;
    exp_t       q[$];

    operand_loader dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sw        (sw),
        .load_btn  (load_btn),
        .clear_btn (clear_btn),
        .A         (A),
        .B         (B),
        .valid     (valid),
        .wait_A_LED(wait_A_LED),
        .wait_B_LED(wait_B_LED),
        .pair_cnt  (pair_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t mk();
        exp_t e;
        e.a  = m_a;
        e.b  = m_b;
        e.v  = m_v;
        e.c  = m_c;
        e.la = (m_st == 0);
        e.lb = (m_st == 1);
        return e;
    endfunction

    task automatic cmp(input string tag, input exp_t e);
        chk({tag, ".A"}, 32'(A), 32'(e.a));
        chk({tag, ".B"}, 32'(B), 32'(e.b));
        chk({tag, ".valid"}, 32'(valid), 32'(e.v));
        chk({tag, ".cnt"}, 32'(pair_cnt), 32'(e.c));
        chk({tag, ".ledA"}, 32'(wait_A_LED), 32'(e.la));
        chk({tag, ".ledB"}, 32'(wait_B_LED), 32'(e.lb));
    endtask

    task automatic model_reset();
        m_a  = '0;
        m_b  = '0;
        m_v  = 1'b0;
        m_c  = '0;
        m_st = 0;
    endtask

    task automatic model_step(input logic ld, input logic cl,
                              input logic [5:0] swv);
        if (cl) begin
            m_a  = '0;
            m_b  = '0;
            m_v  = 1'b0;
            m_st = 0;
        end else if (ld) begin
            case (m_st)
                0: begin
                    m_a  = swv;
                    m_st = 1;
                end
                1: begin
                    m_b  = swv;
                    m_v  = 1'b1;
                    m_c  = m_c + 4'd1;
                    m_st = 2;
                end
                default: begin
                    m_a  = swv;
                    m_v  = 1'b0;
                    m_st = 1;
                end
            endcase
        end
    endtask

    // Button first sampled at edge k; outputs must be old after k+1+LAT
    // and new after k+2+LAT.
    task automatic press(input logic ld, input logic cl,
                         input logic [5:0] swv, input int extra);
        exp_t old;
        exp_t e;
        @(negedge clk);
        sw        = swv;
        load_btn  = ld;
        clear_btn = cl;
        old = mk();
        model_step(ld, cl, swv);
        q.push_back(mk());
        @(posedge clk);
        repeat (1 + LAT) @(posedge clk);
        #1 cmp("pre", old);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("queue", 32'(q.size()), 32'd1);
        end else begin
            e = q.pop_front();
            cmp("post", e);
        end
        repeat (extra) @(posedge clk);
        @(negedge clk);
        load_btn  = 1'b0;
        clear_btn = 1'b0;
        repeat (6 + LAT) @(posedge clk);
        #1 cmp("idle", mk());
    endtask

    initial begin
        reset_n   = 1'b0;
        sw        = '0;
        load_btn  = 1'b0;
        clear_btn = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp("rst", mk());
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1 cmp("rst_rel", mk());

        press(1'b1, 1'b0, 6'h15, 0);
        @(posedge clk);
        #3 reset_n = 1'b0;
        model_reset();
        #1 cmp("async_rst", mk());
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1 cmp("after_rst", mk());

        press(1'b1, 1'b0, 6'b000101, 0);
        press(1'b1, 1'b0, 6'b111101, 0);

        press(1'b0, 1'b1, 6'h00, 0);
        press(1'b1, 1'b0, 6'd7, 20);

        press(1'b1, 1'b1, 6'h2A, 0);

        for (int i = 0; i < 32; i++) begin
            press(1'b1, 1'b0, 6'($urandom_range(0, 63)), 0);
        end
        press(1'b1, 1'b0, 6'd9, 0);

`ifdef OPERAND_DEBOUNCE_EN
        @(negedge clk);
        sw       = 6'h11;
        load_btn = 1'b1;
        repeat (10) @(negedge clk);
        load_btn = 1'b0;
        repeat (40) @(posedge clk);
        #1 cmp("glitch", mk());
`endif

        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
